// File: rtl/apb_master_bridge.sv
`timescale 1ns/1ps
// apb_master_bridge
// APB3 initiator. Turns a valid/ready command from a local requester into one
// APB SETUP/ACCESS transfer and returns read data and error status through a
// single-entry valid/ready response slot. A programmable wait-state timeout
// aborts transfers to a slave that never raises pready.
module apb_master_bridge #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    // command channel
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_write,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
    // response channel
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic                  o_rsp_timeout,
    // APB initiator port
    output logic                  o_psel,
    output logic                  o_penable,
    output logic                  o_pwrite,
    output logic [ADDR_WIDTH-1:0] o_paddr,
    output logic [DATA_WIDTH-1:0] o_pwdata,
    input  logic                  i_pready,
    input  logic [DATA_WIDTH-1:0] i_prdata,
    input  logic                  i_pslverr
);

    // Transfer phase encodings
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    // A zero TIMEOUT_CYCLES turns the abort path off entirely
    localparam logic                 TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST   = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    logic [1:0]           state_q;
    logic [1:0]           state_d;
    logic [CNT_WIDTH-1:0] wait_cnt_q;

    logic cmd_fire;
    logic in_access;
    logic access_done;
    logic access_abort;
    logic rsp_fire;

    // Ready is a pure decode of registered state, never a path from i_cmd_valid
    assign o_cmd_ready = (state_q == ST_IDLE) && !o_rsp_valid;
    assign cmd_fire    = i_cmd_valid && o_cmd_ready;
    assign rsp_fire    = o_rsp_valid && i_rsp_ready;

    assign in_access   = (state_q == ST_ACCESS);
    // pready in the abort cycle takes priority, so the abort term excludes it
    assign access_done  = in_access && i_pready;
    assign access_abort = in_access && !i_pready && TIMEOUT_EN && (wait_cnt_q == CNT_LAST);

    // psel/penable decode straight from the state register so an async reset
    // drops them without waiting for a clock edge
    assign o_psel    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign o_penable = in_access;

    // Next-state selection for the SETUP/ACCESS sequence
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (access_done || access_abort) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Wait-state counter: cleared entering SETUP, counts ACCESS cycles without pready
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wait_cnt_q <= '0;
        end else if (cmd_fire) begin
            wait_cnt_q <= '0;
        end else if (in_access && !i_pready && !access_abort) begin
            wait_cnt_q <= wait_cnt_q + CNT_ONE;
        end
    end

    // Address/direction/data captured at the command handshake and held until the next one
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_pwrite <= 1'b0;
            o_paddr  <= '0;
            o_pwdata <= '0;
        end else if (cmd_fire) begin
            o_pwrite <= i_cmd_write;
            o_paddr  <= i_cmd_addr;
            o_pwdata <= i_cmd_write ? i_cmd_wdata : '0;
        end
    end

    // Single-entry response slot: filled on completion or abort, emptied on handshake
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_rsp_valid   <= 1'b0;
            o_rsp_rdata   <= '0;
            o_rsp_err     <= 1'b0;
            o_rsp_timeout <= 1'b0;
        end else if (access_done) begin
            o_rsp_valid   <= 1'b1;
            o_rsp_rdata   <= o_pwrite ? '0 : i_prdata;
            o_rsp_err     <= i_pslverr;
            o_rsp_timeout <= 1'b0;
        end else if (access_abort) begin
            o_rsp_valid   <= 1'b1;
            o_rsp_rdata   <= '0;
            o_rsp_err     <= 1'b1;
            o_rsp_timeout <= 1'b1;
        end else if (rsp_fire) begin
            o_rsp_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
`timescale 1ns/1ps
// tb_apb_master_bridge
// Scoreboard bench: each issued command pushes its expected response (from a
// transaction-level model) and a slave behaviour plan; a slave process plays
// the plan on the APB side and a monitor pops/compares responses.
module tb_apb_master_bridge;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic          i_clk = 1'b0;
    logic          i_reset_n = 1'b0;
    logic          i_cmd_valid = 1'b0;
    logic          o_cmd_ready;
    logic          i_cmd_write = 1'b0;
    logic [AW-1:0] i_cmd_addr = '0;
    logic [DW-1:0] i_cmd_wdata = '0;
    logic          o_rsp_valid;
    logic          i_rsp_ready = 1'b0;
    logic [DW-1:0] o_rsp_rdata;
    logic          o_rsp_err;
    logic          o_rsp_timeout;
    logic          o_psel;
    logic          o_penable;
    logic          o_pwrite;
    logic [AW-1:0] o_paddr;
    logic [DW-1:0] o_pwdata;
    logic          i_pready = 1'b0;
    logic [DW-1:0] i_prdata = '0;
    logic          i_pslverr = 1'b0;

    apb_master_bridge #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO),
        .CNT_WIDTH      (16)
    ) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_cmd_valid   (i_cmd_valid),
        .o_cmd_ready   (o_cmd_ready),
        .i_cmd_write   (i_cmd_write),
        .i_cmd_addr    (i_cmd_addr),
        .i_cmd_wdata   (i_cmd_wdata),
        .o_rsp_valid   (o_rsp_valid),
        .i_rsp_ready   (i_rsp_ready),
        .o_rsp_rdata   (o_rsp_rdata),
        .o_rsp_err     (o_rsp_err),
        .o_rsp_timeout (o_rsp_timeout),
        .o_psel        (o_psel),
        .o_penable     (o_penable),
        .o_pwrite      (o_pwrite),
        .o_paddr       (o_paddr),
        .o_pwdata      (o_pwdata),
        .i_pready      (i_pready),
        .i_prdata      (i_prdata),
        .i_pslverr     (i_pslverr)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int unsigned   waits;   // ACCESS cycles with pready low before it rises
        logic [DW-1:0] prdata;
        logic          perr;
    } plan_t;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic          tmo;
        int unsigned   hs;      // clock edge of the command handshake
        int unsigned   lat;     // edges from handshake to rsp_valid visible
    } rsp_t;

    plan_t plan_q[$];
    rsp_t  exp_q[$];

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: what the requester should see for a given slave behaviour
    function automatic rsp_t model(input plan_t p, input int unsigned hs);
        rsp_t r;
        r.hs = hs;
        if (p.waits >= TO) begin
            r.rdata = '0;
            r.err   = 1'b1;
            r.tmo   = 1'b1;
            r.lat   = 2 + (TO - 1);
        end else begin
            r.rdata = p.write ? '0 : p.prdata;
            r.err   = p.perr;
            r.tmo   = 1'b0;
            r.lat   = 2 + p.waits;
        end
        return r;
    endfunction

    function automatic plan_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                 input int unsigned waits, input logic [DW-1:0] prd, input logic e);
        plan_t p;
        p.write = w; p.addr = a; p.wdata = d; p.waits = waits; p.prdata = prd; p.perr = e;
        return p;
    endfunction

    // Issue one command (called at a negedge); junk is presented while not ready
    task automatic issue(input plan_t p);
        int unsigned k = 0;
        while (!o_cmd_ready && k < 500) begin
            i_cmd_valid = 1'b1;
            i_cmd_write = 1'($urandom);
            i_cmd_addr  = $urandom;
            i_cmd_wdata = $urandom;
            @(negedge i_clk);
            k++;
        end
        if (!o_cmd_ready) begin
            chk("cmd_ready_wait", 64'(o_cmd_ready), 64'(1));
        end else begin
            i_cmd_valid = 1'b1;
            i_cmd_write = p.write;
            i_cmd_addr  = p.addr;
            i_cmd_wdata = p.wdata;
            plan_q.push_back(p);
            exp_q.push_back(model(p, cyc + 1));
            @(negedge i_clk);
            i_cmd_valid = 1'b0;
            i_cmd_write = 1'($urandom);
            i_cmd_addr  = $urandom;
            i_cmd_wdata = $urandom;
        end
    endtask

    task automatic drain();
        int unsigned k = 0;
        while ((exp_q.size() != 0 || o_psel) && k < 300) begin
            @(negedge i_clk);
            k++;
        end
        chk("drain", 64'(exp_q.size()), 64'(0));
        @(negedge i_clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_psel"},    64'(o_psel),        64'(0));
        chk({tag, "_penable"}, 64'(o_penable),     64'(0));
        chk({tag, "_rspv"},    64'(o_rsp_valid),   64'(0));
        chk({tag, "_err"},     64'(o_rsp_err),     64'(0));
        chk({tag, "_tmo"},     64'(o_rsp_timeout), 64'(0));
        chk({tag, "_rdata"},   64'(o_rsp_rdata),   64'(0));
        chk({tag, "_paddr"},   64'(o_paddr),       64'(0));
        chk({tag, "_pwdata"},  64'(o_pwdata),      64'(0));
        chk({tag, "_pwrite"},  64'(o_pwrite),      64'(0));
    endtask

    // APB slave: plays the plan of the current transfer, drives junk otherwise
    plan_t       cur;
    logic        active    = 1'b0;
    logic        prev_psel = 1'b0;
    int unsigned acc       = 0;

    always @(negedge i_clk) begin
        if (i_reset_n) begin
            if (o_psel && !o_penable) begin
                chk("idle_gap", 64'(prev_psel), 64'(0));
                if (plan_q.size() == 0) begin
                    chk("unexpected_setup", 64'(plan_q.size()), 64'(1));
                    active = 1'b0;
                end else begin
                    cur    = plan_q.pop_front();
                    active = 1'b1;
                    acc    = 0;
                end
            end
            if (o_psel && active) begin
                chk("paddr",  64'(o_paddr),  64'(cur.addr));
                chk("pwrite", 64'(o_pwrite), 64'(cur.write));
                chk("pwdata", 64'(o_pwdata), cur.write ? 64'(cur.wdata) : 64'(0));
            end
            if (o_penable) begin
                chk("enable_after_setup", 64'(prev_psel), 64'(1));
                chk("access_bound", 64'(acc < TO), 64'(1));
                if (active && acc == cur.waits) begin
                    i_pready  = 1'b1;
                    i_prdata  = cur.prdata;
                    i_pslverr = cur.perr;
                end else begin
                    i_pready  = 1'b0;
                    i_prdata  = $urandom;
                    i_pslverr = 1'($urandom);
                end
                acc++;
            end else begin
                i_pready  = 1'($urandom);
                i_prdata  = $urandom;
                i_pslverr = 1'($urandom);
            end
            prev_psel = o_psel;
        end
    end

    // Response monitor: pops expectations, drives rsp_ready (held low on request)
    int unsigned hold_left = 0;
    logic        rsp_rand  = 1'b0;
    logic        rsp_seen  = 1'b0;
    logic        consumed  = 1'b0;

    always @(negedge i_clk) begin
        rsp_t e;
        if (i_reset_n) begin
            if (consumed) begin
                chk("rsp_cleared",         64'(o_rsp_valid), 64'(0));
                chk("ready_after_consume", 64'(o_cmd_ready), 64'(1));
                consumed = 1'b0;
            end
            if (o_rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 64'(exp_q.size()), 64'(1));
                    i_rsp_ready = 1'b1;
                end else begin
                    e = exp_q[0];
                    if (!rsp_seen) begin
                        chk("latency", 64'(cyc - e.hs), 64'(e.lat));
                        rsp_seen = 1'b1;
                    end
                    chk("rsp_rdata",      64'(o_rsp_rdata),   64'(e.rdata));
                    chk("rsp_err",        64'(o_rsp_err),     64'(e.err));
                    chk("rsp_timeout",    64'(o_rsp_timeout), 64'(e.tmo));
                    chk("busy_cmd_ready", 64'(o_cmd_ready),   64'(0));
                    chk("busy_psel",      64'(o_psel),        64'(0));
                    if (hold_left > 0) begin
                        hold_left--;
                        i_rsp_ready = 1'b0;
                    end else begin
                        i_rsp_ready = rsp_rand ? 1'($urandom) : 1'b1;
                    end
                    if (i_rsp_ready) begin
                        void'(exp_q.pop_front());
                        rsp_seen = 1'b0;
                        consumed = 1'b1;
                    end
                end
            end else begin
                i_rsp_ready = 1'($urandom);
            end
        end
    end

    initial begin
        int unsigned k;
        repeat (3) @(negedge i_clk);
        chk_reset_outputs("reset");
        #1 i_reset_n = 1'b1;
        @(negedge i_clk);

        // Directed: zero-wait write, 3-wait read, slave error, timeout, pready on last cycle
        issue(mk(1'b1, 32'h0000_0010, 32'hA5A5_1234, 0, 32'h1111_1111, 1'b0));
        issue(mk(1'b0, 32'h0000_0020, 32'h0,         3, 32'hDEAD_BEEF, 1'b0));
        issue(mk(1'b0, 32'h0000_0030, 32'h0,         0, 32'h1234_5678, 1'b1));
        issue(mk(1'b0, 32'h0000_0040, 32'h0,        20, 32'hCAFE_F00D, 1'b0));
        issue(mk(1'b1, 32'h0000_0044, 32'h5555_AAAA,20, 32'h0,         1'b0));
        issue(mk(1'b0, 32'h0000_0048, 32'h0,    TO - 1, 32'h0BAD_CAFE, 1'b0));
        drain();

        // Backpressure: response held for 5 cycles while the next command waits
        hold_left = 5;
        issue(mk(1'b1, 32'h0000_0100, 32'h0F0F_0F0F, 1, 32'h0, 1'b0));
        issue(mk(1'b0, 32'h0000_0104, 32'h0,         0, 32'h7777_8888, 1'b0));
        drain();

        // Reset in the middle of a wait state
        issue(mk(1'b0, 32'h0000_0200, 32'h0, 20, 32'h9999_9999, 1'b0));
        k = 0;
        while (!(o_psel && o_penable) && k < 20) begin
            @(negedge i_clk);
            k++;
        end
        chk("reach_access", 64'(o_penable), 64'(1));
        #2 i_reset_n = 1'b0;
        #1 chk_reset_outputs("async_reset");
        plan_q.delete();
        exp_q.delete();
        active    = 1'b0;
        prev_psel = 1'b0;
        rsp_seen  = 1'b0;
        consumed  = 1'b0;
        hold_left = 0;
        @(negedge i_clk);
        @(negedge i_clk);
        #1 i_reset_n = 1'b1;
        @(negedge i_clk);
        issue(mk(1'b0, 32'h0000_0300, 32'h0, 1, 32'h3141_5926, 1'b0));
        issue(mk(1'b1, 32'h0000_0304, 32'hFACE_B00C, 0, 32'h0, 1'b0));
        drain();

        // Randomized traffic with random response backpressure
        rsp_rand = 1'b1;
        for (int i = 0; i < 60; i++) begin
            issue(mk(1'($urandom), $urandom, $urandom, $urandom_range(0, TO + 1),
                     $urandom, 1'($urandom)));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global safety net so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule
